mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Sits directly downstream of the operand selector: consumes opnum1/opnum2 plus func3, and produces a result for the ex-stage writeback mux into the regfile.
- Multi-cycle: asserts busy_o so the control unit holds the PC and suppresses the regfile write until done_o.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start_i  input  1  launch request; sampled only in IDLE
flush_i  input  1  abort current operation
op_i  input  3  M-extension func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opnum1_i  input  XLEN  rs1 operand (multiplicand / dividend)
opnum2_i  input  XLEN  rs2 operand (multiplier / divisor)
busy_o  output  1  high while an operation is in flight (state MUL or DIV)
done_o  output  1  single-cycle pulse; result_o valid this cycle
result_o  output  XLEN  result; holds last value until next done_o

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, op_i[2]=0:
  - Latch |opnum1| and |opnum2| according to signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - Latch the result-negate flag and the op.
  - Clear a 2*XLEN accumulator and the counter; go to MUL.
- MUL: radix-2 shift-add, one multiplier bit per cycle, counter 0..XLEN-1. After the XLEN-th iteration go to DONE.
- IDLE, start_i=1, op_i[2]=1:
  - Divisor zero: fast path directly to DONE. DIV/DIVU give all-ones; REM/REMU give opnum1_i.
  - Signed overflow (DIV/REM, opnum1=0x8000_0000, opnum2=0xFFFF_FFFF): fast path to DONE. DIV gives 0x8000_0000; REM gives 0.
  - Otherwise latch absolute values (signed ops only) and the quotient/remainder sign flags, then go to DIV.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles, then go to DONE.
- DONE:
  - done_o=1 for exactly this cycle; result_o updates on the edge entering DONE.
  - Result selection:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Negation applied before selection: the full 2*XLEN product is negated if the operand signs differ (signed ops). The quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - DONE always returns to IDLE on the next edge. start_i in DONE is ignored.
- Latency:
  - Normal ops: start edge at cycle 0; done_o high in cycle XLEN+1 (33 for XLEN=32).
  - Fast-path ops: done_o high in cycle 1.
- busy_o = (state==MUL || state==DIV). It is low in IDLE and DONE.
- start_i while busy: ignored; operands are not re-latched.
- Inputs need only be stable on the start edge; they are don't-care afterwards.
- flush_i = 1:
  - Takes priority over everything, including start_i in the same cycle.
  - Next state is IDLE; no done_o pulse; result_o keeps its previous value.
  - flush_i in DONE: done_o still shows this cycle, and the state goes to IDLE.
- rst asserted mid-operation: immediate IDLE; outputs go to reset values.
- Back-to-back: a start_i on the cycle after DONE (state IDLE) is accepted normally.

Test Plan:
- Reset: hold rst=0 mid-MUL, release -> busy_o=0, done_o=0, result_o=0; a following start is accepted normally.
- MUL/MULH: opnum1=0xFFFF_FFFF (-1), opnum2=0x0000_0002, op=000 -> done_o at cycle 33, result_o=0xFFFF_FFFE. Same operands with op=001 -> 0xFFFF_FFFF. Same operands with op=011 (MULHU) -> 0x0000_0001.
- DIV/REM signs: opnum1=0xFFFF_FFF9 (-7), opnum2=2. op=100 -> 0xFFFF_FFFD (-3); op=110 -> 0xFFFF_FFFF (-1); op=101 (DIVU) -> 0x7FFF_FFFC.
- Fast paths: opnum2=0 with opnum1=0x1234 -> DIVU gives 0xFFFF_FFFF and REMU gives 0x1234, each with done_o at cycle 1. Overflow 0x8000_0000 / 0xFFFF_FFFF: DIV gives 0x8000_0000, REM gives 0, both at cycle 1.
- Busy handling: start MUL 3*5, then pulse start_i with different operands at cycle 10 -> ignored; done_o at cycle 33 with result_o=15.
- Flush: start DIV 100/7; flush_i at cycle 12 -> busy_o low in cycle 13, no done_o, result_o unchanged. Restart DIV 100/7 -> done_o at cycle 33, result_o=14. Then REM 100/7 started the cycle after that DONE -> result_o=2.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Latency XLEN+1 cycles from the start edge to done_o (1 cycle for divide-by-zero/overflow); start ignored while busy.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opnum1_i,
  input  logic [XLEN-1:0] opnum2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [2*XLEN-1:0] acc;
  logic [1:0]        op_r;
  logic              neg_res, neg_rem;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, last;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_acc, div_acc, prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res;

  // Operand signedness from func3: divides are signed when op[0]=0; MULHSU has unsigned rs2.
  always_comb begin
    a_sgn    = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = op_i[2] ? ~op_i[0] : ~op_i[1];
    a_neg    = a_sgn & opnum1_i[XLEN-1];
    b_neg    = b_sgn & opnum2_i[XLEN-1];
    a_abs    = a_neg ? -opnum1_i : opnum1_i;
    b_abs    = b_neg ? -opnum2_i : opnum2_i;
    div_zero = (opnum2_i == '0);
    div_ovf  = ~op_i[0] & (opnum1_i == MIN_NEG) & (opnum2_i == '1);
    last     = (cnt == CW'(XLEN-1));
  end

  // Multiply: add multiplicand into the high half when the current multiplier bit is set, then shift right.
  // Divide: acc holds {partial remainder, dividend/quotient}; quotient bits enter at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    mul_acc   = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_trial = div_shift - {1'b0, b_reg};
    div_acc   = {(div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0]),
                 acc[XLEN-2:0], ~div_trial[XLEN]};
    prod      = neg_res ? -mul_acc : mul_acc;
    quo       = neg_res ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
    rem       = neg_rem ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];
    mul_res   = (op_r == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res   = op_r[1] ? rem : quo;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (!op_i[2])                 state_nxt = MUL;
          else if (div_zero || div_ovf) state_nxt = DONE;
          else                          state_nxt = DIV;
        end
      end
      MUL:     if (last) state_nxt = DONE;
      DIV:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      op_r     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt     <= '0;
            a_reg   <= a_abs;
            b_reg   <= b_abs;
            op_r    <= op_i[1:0];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= op_i[2] ? {{XLEN{1'b0}}, a_abs} : '0;
            if (op_i[2] && div_zero)
              result_o <= op_i[1] ? opnum1_i : '1;
            else if (op_i[2] && div_ovf)
              result_o <= op_i[1] ? '0 : MIN_NEG;
          end
        end
        MUL: begin
          acc   <= mul_acc;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (last) result_o <= mul_res;
        end
        DIV: begin
          acc <= div_acc;
          cnt <= cnt + 1'b1;
          if (last) result_o <= div_res;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state == MUL) || (state == DIV);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboarded bench for mdu_iter: directed cases plus randomized ops against a 64-bit arithmetic model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] opnum1_i, opnum2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mdu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
    .opnum1_i(opnum1_i), .opnum2_i(opnum2_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: extend operands to 64 bits per signedness and use plain arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb2;
    sa  = a;
    sb2 = b;
    ea  = {32'h0, a};
    eb  = {32'h0, b};
    if (op == 3'd0 || op == 3'd1 || op == 3'd2) ea = {{32{a[31]}}, a};
    if (op == 3'd0 || op == 3'd1)               eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb2;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb2;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input logic [31:0] exp_res, output int t0);
    exp_t x;
    @(negedge clk);
    op_i = op; opnum1_i = a; opnum2_i = b; start_i = 1'b1;
    t0 = cyc;
    if (track) begin
      x.res = exp_res;
      x.cyc = t0 + (is_fast(op, a, b) ? 1 : 33);
      x.op  = op;
      sb.push_back(x);
    end
    @(negedge clk);
    start_i  = 1'b0;
    op_i     = 3'($urandom_range(0, 7));
    opnum1_i = $urandom;
    opnum2_i = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst && done_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done_o at cycle %0d result %h, required no done", cyc, result_o);
      end else begin
        e = sb.pop_front();
        if (result_o !== e.res) begin
          errors++;
          $display("FAIL result op=%0d: got %h, required %h", e.op, result_o, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency op=%0d: done at cycle %0d, required %0d", e.op, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    logic [31:0] prev;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; opnum1_i = '0; opnum2_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   {31'h0, busy_o}, 32'h0);
    chk("reset_done",   {31'h0, done_o}, 32'h0);
    chk("reset_result", result_o,        32'h0);
    rst = 1'b1;

    // Reset in the middle of a multiply kills it.
    issue(3'b000, 32'd5, 32'd7, 1'b0, 32'h0, t0);
    repeat (8) @(negedge clk);
    chk("midop_busy_before", {31'h0, busy_o}, 32'h1);
    rst = 1'b0;
    #1;
    chk("midop_reset_busy",   {31'h0, busy_o}, 32'h0);
    chk("midop_reset_done",   {31'h0, done_o}, 32'h0);
    chk("midop_reset_result", result_o,        32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    issue(3'b000, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, t0); wait_done();
    issue(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF, t0); wait_done();
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h0000_0001, t0); wait_done();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, t0); wait_done();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, t0); wait_done();
    issue(3'b101, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, t0); wait_done();
    issue(3'b101, 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, t0); wait_done();
    issue(3'b111, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, t0); wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, t0); wait_done();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, t0); wait_done();

    // A start while busy must not disturb the operation in flight.
    issue(3'b000, 32'd3, 32'd5, 1'b1, 32'd15, t0);
    while (cyc < t0 + 10) @(negedge clk);
    chk("busy_mid_mul", {31'h0, busy_o}, 32'h1);
    start_i = 1'b1; op_i = 3'b100; opnum1_i = 32'd99; opnum2_i = 32'd4;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // Flush aborts silently; result_o keeps the previous value.
    prev = result_o;
    issue(3'b100, 32'd100, 32'd7, 1'b0, 32'h0, t0);
    while (cyc < t0 + 12) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy",   {31'h0, busy_o}, 32'h0);
    chk("flush_result", result_o,        prev);
    repeat (40) @(negedge clk);

    issue(3'b100, 32'd100, 32'd7, 1'b1, 32'd14, t0);
    n = 0;
    while (!done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    issue(3'b110, 32'd100, 32'd7, 1'b1, 32'd2, t0);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rv();
      b  = rv();
      issue(op, a, b, 1'b1, ref_mdu(op, a, b), t0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
